// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear sequencer for a two-digit BCD up-counter.
// Turns debounced button levels into single-cycle events, gates the time-base
// tick into the counter carry-in, requests counter clears, and selects either a
// frozen lap snapshot or the live count for the display.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   tick                  one-cycle time-base strobe
//   btn_start, btn_lap    debounced button levels, active-high
//   cnt_ones, cnt_tens    live BCD digits from the counter pair
//   cnt_en                counter carry-in (combinational)
//   cnt_clr               one-cycle synchronous clear request (registered)
//   disp_ones, disp_tens  digits shown on the display
//   state_o               current state code
module stopwatch_ctrl #(
  parameter int unsigned CNT_BIT_WIDTH = 4,
  parameter int unsigned LIMIT         = 9,
  parameter bit          STOP_AT_LIMIT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     btn_start,
  input  logic                     btn_lap,
  input  logic [CNT_BIT_WIDTH-1:0] cnt_ones,
  input  logic [CNT_BIT_WIDTH-1:0] cnt_tens,
  output logic                     cnt_en,
  output logic                     cnt_clr,
  output logic [CNT_BIT_WIDTH-1:0] disp_ones,
  output logic [CNT_BIT_WIDTH-1:0] disp_tens,
  output logic [2:0]               state_o
);

  localparam logic [CNT_BIT_WIDTH-1:0] LIMIT_V = CNT_BIT_WIDTH'(LIMIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic                     btn_start_q, btn_lap_q;
  logic                     cnt_clr_q, cnt_clr_d;
  logic [CNT_BIT_WIDTH-1:0] lap_ones_q, lap_tens_q;
  logic                     lap_load;

  logic ev_start, ev_lap, term, counting;

  // Rising-edge events; the _q copies reset high so a held button is ignored.
  assign ev_start = btn_start & ~btn_start_q;
  assign ev_lap   = btn_lap   & ~btn_lap_q;

  // Terminal count only stops the watch when STOP_AT_LIMIT is set.
  assign term = STOP_AT_LIMIT & tick & (cnt_tens == LIMIT_V) & (cnt_ones == LIMIT_V);

  assign counting = (state_q == RUN) | (state_q == LAP);

  // Next-state, clear request and snapshot load.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    lap_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_start) begin
          state_d = RUN;
        end else if (ev_lap) begin
          cnt_clr_d = 1'b1;
        end
      end
      RUN: begin
        if (ev_start) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d  = LAP;
          lap_load = 1'b1;
        end else if (term) begin
          state_d = DONE;
        end
      end
      LAP: begin
        if (ev_start) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d = RUN;
        end else if (term) begin
          state_d = DONE;
        end
      end
      PAUSE: begin
        if (ev_start) begin
          state_d = RUN;
        end else if (ev_lap) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      DONE: begin
        if (ev_lap) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, button history, clear pulse and lap snapshot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      btn_start_q <= 1'b1;
      btn_lap_q   <= 1'b1;
      cnt_clr_q   <= 1'b0;
      lap_ones_q  <= '0;
      lap_tens_q  <= '0;
    end else begin
      state_q     <= state_d;
      btn_start_q <= btn_start;
      btn_lap_q   <= btn_lap;
      cnt_clr_q   <= cnt_clr_d;
      if (lap_load) begin
        lap_ones_q <= cnt_ones;
        lap_tens_q <= cnt_tens;
      end
    end
  end

  // Reset gating keeps the counter frozen and the display live while rst_n is low.
  assign cnt_en    = rst_n & tick & counting & ~term;
  assign cnt_clr   = cnt_clr_q;
  assign disp_ones = (rst_n && state_q == LAP) ? lap_ones_q : cnt_ones;
  assign disp_tens = (rst_n && state_q == LAP) ? lap_tens_q : cnt_tens;
  assign state_o   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (stop-at-limit and wrapping) share
// buttons and tick; each drives its own BCD counter model. A behavioural
// reference is compared every cycle, plus literal checks along the scenario.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n, tick, btn_start, btn_lap;

  logic       en_w   [2];
  logic       clr_w  [2];
  logic [3:0] dones_w[2];
  logic [3:0] dtens_w[2];
  logic [2:0] state_w[2];
  logic [3:0] c_ones [2];
  logic [3:0] c_tens [2];

  int cnt[2] = '{0, 0};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign c_ones[0] = 4'(cnt[0] % 10);
  assign c_tens[0] = 4'(cnt[0] / 10);
  assign c_ones[1] = 4'(cnt[1] % 10);
  assign c_tens[1] = 4'(cnt[1] / 10);

  stopwatch_ctrl #(.CNT_BIT_WIDTH(4), .LIMIT(9), .STOP_AT_LIMIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_start(btn_start), .btn_lap(btn_lap),
    .cnt_ones(c_ones[0]), .cnt_tens(c_tens[0]),
    .cnt_en(en_w[0]), .cnt_clr(clr_w[0]),
    .disp_ones(dones_w[0]), .disp_tens(dtens_w[0]), .state_o(state_w[0]));

  stopwatch_ctrl #(.CNT_BIT_WIDTH(4), .LIMIT(9), .STOP_AT_LIMIT(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_start(btn_start), .btn_lap(btn_lap),
    .cnt_ones(c_ones[1]), .cnt_tens(c_tens[1]),
    .cnt_en(en_w[1]), .cnt_clr(clr_w[1]),
    .disp_ones(dones_w[1]), .disp_tens(dtens_w[1]), .state_o(state_w[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state code, pending clear, lap value as 0..99.
  int m_state[2];
  bit m_clr[2];
  int m_snap[2];
  bit bs_prev, bl_prev;
  bit armed = 1'b0;

  always @(posedge clk) begin
    bit es, el, term;
    int ns;
    bit nc;
    es = btn_start && !bs_prev;
    el = btn_lap && !bl_prev;
    for (int k = 0; k < 2; k++) begin
      // Counter pair reacting to the DUT.
      if (clr_w[k]) cnt[k] <= 0;
      else if (en_w[k]) cnt[k] <= (cnt[k] + 1) % 100;
      if (!rst_n) begin
        m_state[k] <= 0;
        m_clr[k]   <= 1'b0;
        m_snap[k]  <= 0;
      end else begin
        term = (k == 0) && tick && (cnt[k] == 99);
        ns = m_state[k];
        nc = 1'b0;
        if (m_state[k] == 4) begin
          if (el) begin ns = 0; nc = 1'b1; end
        end else if (es) begin
          ns = (m_state[k] == 1 || m_state[k] == 2) ? 3 : 1;
        end else if (el) begin
          case (m_state[k])
            0: nc = 1'b1;
            1: begin ns = 2; m_snap[k] <= cnt[k]; end
            2: ns = 1;
            default: begin ns = 0; nc = 1'b1; end
          endcase
        end else if (term && (m_state[k] == 1 || m_state[k] == 2)) begin
          ns = 4;
        end
        m_state[k] <= ns;
        m_clr[k]   <= nc;
      end
    end
    if (!rst_n) begin
      bs_prev <= 1'b1;
      bl_prev <= 1'b1;
      armed   <= 1'b1;
    end else begin
      bs_prev <= btn_start;
      bl_prev <= btn_lap;
    end
  end

  // Per-cycle comparison of every output of both instances.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        bit term, exp_en;
        int shown;
        term   = (k == 0) && tick && (cnt[k] == 99);
        exp_en = rst_n && tick && (m_state[k] == 1 || m_state[k] == 2) && !term;
        shown  = (rst_n && m_state[k] == 2) ? m_snap[k] : cnt[k];
        chk($sformatf("state%0d", k), int'(state_w[k]), m_state[k]);
        chk($sformatf("cnt_en%0d", k), int'(en_w[k]), int'(exp_en));
        chk($sformatf("cnt_clr%0d", k), int'(clr_w[k]), int'(m_clr[k]));
        chk($sformatf("disp_ones%0d", k), int'(dones_w[k]), shown % 10);
        chk($sformatf("disp_tens%0d", k), int'(dtens_w[k]), shown / 10);
      end
    end
  end

  task automatic drive(input bit t, input bit bs, input bit bl);
    tick = t; btn_start = bs; btn_lap = bl;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit t, input bit bs, input bit bl);
    drive(t, bs, bl);
    edge_wait();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_start();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_lap();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; btn_start = 1'b1; btn_lap = 1'b0;
    edge_wait();
    edge_wait();
    chk("rst_state", int'(state_w[0]), 0);
    chk("rst_clr", int'(clr_w[0]), 0);
    chk("rst_disp", int'(dones_w[0]), 0);

    // Start held through reset release: no event.
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("held_start", int'(state_w[0]), 0);
    step(1'b0, 1'b0, 1'b0);
    press_start();
    chk("run_state", int'(state_w[0]), 1);

    drive(1'b1, 1'b0, 1'b0);
    chk("en_on_tick", int'(en_w[0]), 1);
    edge_wait();
    ticks(4);
    chk("count5_ones", int'(dones_w[0]), 5);
    chk("count5_tens", int'(dtens_w[0]), 0);

    // Lap at 12, count on to 15 while showing 12.
    ticks(7);
    press_lap();
    ticks(3);
    chk("lap_state", int'(state_w[0]), 2);
    chk("lap_disp_ones", int'(dones_w[0]), 2);
    chk("lap_disp_tens", int'(dtens_w[0]), 1);
    chk("lap_live", cnt[0], 15);
    press_lap();
    chk("unlap_state", int'(state_w[0]), 1);
    chk("unlap_disp", int'(dones_w[0]), 5);

    // Pause ignores ticks; lap from pause clears.
    press_start();
    chk("pause_state", int'(state_w[0]), 3);
    ticks(3);
    chk("pause_count", cnt[0], 15);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_pulse", int'(clr_w[0]), 1);
    chk("clr_idle", int'(state_w[0]), 0);
    chk("clr_pending_cnt", cnt[0], 15);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_drop", int'(clr_w[0]), 0);
    chk("cleared", cnt[0], 0);

    // Run to the limit: stop instance ends in DONE, wrap instance rolls over.
    press_start();
    ticks(99);
    chk("at99", cnt[0], 99);
    chk("at99_state", int'(state_w[0]), 1);
    drive(1'b1, 1'b0, 1'b0);
    chk("term_en", int'(en_w[0]), 0);
    chk("wrap_en", int'(en_w[1]), 1);
    edge_wait();
    chk("done_state", int'(state_w[0]), 4);
    chk("done_count", cnt[0], 99);
    chk("wrap_state", int'(state_w[1]), 1);
    chk("wrap_count", cnt[1], 0);
    press_start();
    chk("done_ignores_start", int'(state_w[0]), 4);
    press_lap();
    chk("done_lap_idle", int'(state_w[0]), 0);
    chk("done_cleared", cnt[0], 0);

    // Simultaneous start+lap while running: start wins.
    press_start();
    ticks(4);
    step(1'b0, 1'b1, 1'b1);
    chk("both_pause", int'(state_w[0]), 3);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of LAP.
    press_start();
    ticks(3);
    press_lap();
    ticks(2);
    chk("lap7_disp", int'(dones_w[0]), 7);
    chk("lap7_live", cnt[0], 9);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    chk("rst_hold_disp", int'(dones_w[0]), 9);
    chk("rst_hold_en", int'(en_w[0]), 0);
    edge_wait();
    chk("rst_lap_state", int'(state_w[0]), 0);
    chk("rst_lap_clr", int'(clr_w[0]), 0);
    chk("rst_keeps_count", cnt[0], 9);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
